alu_serial_ctrl: RTL



---
 rtl/alu_serial_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: streams WIDTH operand bits LSB first,
// recirculates the slice carry and assembles result and flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             slice_invA,
  output logic             slice_A,
  output logic             slice_enA,
  output logic             slice_B,
  output logic             slice_enB,
  output logic             slice_cin,
  output logic             slice_f1,
  output logic             slice_f0,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] CMD_ILLEGAL = 3'b111;

  logic [1:0]       state;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [4:0]       ctl;
  logic             is_arith;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // {invA, enA, enB, f1, f0} per opcode
  function automatic logic [4:0] decode_ctl(input logic [2:0] c);
    case (c)
      3'b000:  decode_ctl = 5'b0_1_1_11;
      3'b001:  decode_ctl = 5'b1_1_1_11;
      3'b010:  decode_ctl = 5'b0_1_1_00;
      3'b011:  decode_ctl = 5'b0_1_1_01;
      3'b100:  decode_ctl = 5'b0_0_1_10;
      3'b101:  decode_ctl = 5'b1_1_0_11;
      3'b110:  decode_ctl = 5'b0_1_0_11;
      default: decode_ctl = 5'b0_0_0_00;
    endcase
  endfunction

  function automatic logic init_cin(input logic [2:0] c);
    init_cin = (c == 3'b001) || (c == 3'b101);
  endfunction

  always_comb begin
    ctl      = decode_ctl(cmd_q);
    is_arith = (cmd_q == 3'b000) || (cmd_q == 3'b001) ||
               (cmd_q == 3'b101) || (cmd_q == 3'b110);
    last_bit = (cnt == CW'(WIDTH - 1));
    res_next = {slice_out, res_sh[WIDTH-1:1]};
  end

  assign ready = (state == S_IDLE);
  assign done  = (state == S_DONE);

  // Slice is only driven while a bit is actually being processed.
  always_comb begin
    slice_invA = 1'b0;
    slice_enA  = 1'b0;
    slice_enB  = 1'b0;
    slice_f1   = 1'b0;
    slice_f0   = 1'b0;
    slice_A    = 1'b0;
    slice_B    = 1'b0;
    slice_cin  = 1'b0;
    if (state == S_RUN) begin
      {slice_invA, slice_enA, slice_enB, slice_f1, slice_f0} = ctl;
      slice_A   = a_sh[0];
      slice_B   = b_sh[0];
      slice_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cmd_q  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && cmd == CMD_ILLEGAL) begin
            err <= 1'b1;
          end else if (start) begin
            cmd_q  <= cmd;
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= init_cin(cmd);
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= slice_cout;
          if (last_bit) begin
            // carry still holds the carry into the MSB here
            result <= res_next;
            cout   <= is_arith & slice_cout;
            ovf    <= is_arith & (carry ^ slice_cout);
            zero   <= (res_next == '0);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
